// File: rtl/hex_display_arbiter.sv
// Fixed-priority owner arbitration for the eight-digit seven-segment display,
// with a minimum hold window per grant and an optional blink of the owner's pattern.
module hex_display_arbiter #(
  parameter int NREQ      = 3,
  parameter int HOLD_CYC  = 50000000,
  parameter int BLINK_CYC = 12500000,
  parameter int CNT_W     = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*56-1:0] pat_i,
  input  logic [NREQ-1:0]   blink_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  output logic              hold_o,
  output logic [6:0]        hex0_o,
  output logic [6:0]        hex1_o,
  output logic [6:0]        hex2_o,
  output logic [6:0]        hex3_o,
  output logic [6:0]        hex4_o,
  output logic [6:0]        hex5_o,
  output logic [6:0]        hex6_o,
  output logic [6:0]        hex7_o
);

  localparam logic [6:0]       DARK       = 7'h7F;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_ph;
  logic [55:0]      hex_q;

  logic [NREQ-1:0]  pri_oh;
  logic [NREQ-1:0]  next_grant;
  logic             any_req;
  logic             owner_req;
  logic             higher_req;
  logic             owner_blink;
  logic             new_grant;
  logic             next_ph;
  logic [55:0]      next_pat;

  always_comb begin
    // Two's-complement trick isolates the lowest set request bit (highest priority).
    pri_oh      = req_i & (~req_i + NREQ'(1));
    any_req     = |req_i;
    owner_req   = |(req_i & grant_o);
    higher_req  = |(req_i & (grant_o - NREQ'(1)));
    owner_blink = |(blink_i & grant_o);

    new_grant = 1'b0;
    case (state)
      IDLE:    new_grant = any_req;
      HOLD:    new_grant = !owner_req;
      OPEN:    new_grant = !owner_req || higher_req;
      default: new_grant = 1'b1;
    endcase

    next_grant = new_grant ? pri_oh : grant_o;

    if (new_grant || !owner_blink)
      next_ph = 1'b1;
    else if (blink_cnt == BLINK_LAST)
      next_ph = ~blink_ph;
    else
      next_ph = blink_ph;

    next_pat = '0;
    for (int k = 0; k < NREQ; k++)
      if (next_grant[k]) next_pat |= pat_i[56*k +: 56];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      hold_o    <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
      hex_q     <= {8{DARK}};
    end else begin
      grant_o  <= next_grant;
      busy_o   <= |next_grant;
      blink_ph <= next_ph;
      hex_q    <= (|next_grant && next_ph) ? next_pat : {8{DARK}};

      if (new_grant || !owner_blink || blink_cnt == BLINK_LAST)
        blink_cnt <= '0;
      else
        blink_cnt <= blink_cnt + CNT_W'(1);

      // A drop with nothing else pending also lands here and falls back to IDLE.
      if (new_grant) begin
        hold_cnt <= '0;
        state    <= (|next_grant) ? HOLD : IDLE;
        hold_o   <= |next_grant;
      end else if (state == HOLD) begin
        if (hold_cnt == HOLD_LAST) begin
          state  <= OPEN;
          hold_o <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign hex0_o = hex_q[6:0];
  assign hex1_o = hex_q[13:7];
  assign hex2_o = hex_q[20:14];
  assign hex3_o = hex_q[27:21];
  assign hex4_o = hex_q[34:28];
  assign hex5_o = hex_q[41:35];
  assign hex6_o = hex_q[48:42];
  assign hex7_o = hex_q[55:49];

endmodule
